cr16_multicycle_core: RTL and testbench

//  Parametrised multicycle CR16-subset execute core: register file, ALU, immediate extension and a 4-state control FSM.

---
 rtl/cr16_pkg.sv | 66 ++++++
 rtl/cr16_if.sv | 23 ++
 rtl/cr16_alu_unit.sv | 54 +++++
 rtl/cr16_multicycle_core.sv | 277 +++++++++++++++++++++++++++
 tb/tb_cr16_multicycle_core.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cr16_pkg.sv
// Shared definitions for the CR16-subset multicycle execute core:
// FSM states, opcode/extension encodings, flag bit positions and ALU selects.
package cr16_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_MOVB = 3'd5,
    ALU_SHL  = 3'd6,
    ALU_SHR  = 3'd7
  } alu_op_t;

  // Which flag group an instruction updates at writeback
  typedef enum logic [1:0] {
    FU_NONE  = 2'd0,
    FU_ARITH = 2'd1,
    FU_CMP   = 2'd2
  } flag_upd_t;

  localparam logic [3:0] OP_RR    = 4'h0;
  localparam logic [3:0] OP_SHIFT = 4'h8;
  localparam logic [3:0] OP_LDX   = 4'hF;

  // Register-form extension codes; the I-form reuses the same values as op
  localparam logic [3:0] EXT_ADD = 4'h5;
  localparam logic [3:0] EXT_SUB = 4'h9;
  localparam logic [3:0] EXT_CMP = 4'hB;
  localparam logic [3:0] EXT_AND = 4'h1;
  localparam logic [3:0] EXT_OR  = 4'h2;
  localparam logic [3:0] EXT_XOR = 4'h3;
  localparam logic [3:0] EXT_MOV = 4'hD;
  localparam logic [3:0] EXT_LSH = 4'h4;

  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  // True for the seven ALU codes shared by the RR and I forms
  function automatic logic is_alu_code(input logic [3:0] code);
    case (code)
      EXT_ADD, EXT_SUB, EXT_CMP, EXT_AND, EXT_OR, EXT_XOR, EXT_MOV: is_alu_code = 1'b1;
      default: is_alu_code = 1'b0;
    endcase
  endfunction

  // Arithmetic immediates are sign-extended, logical/move immediates zero-extended
  function automatic logic uses_sext(input logic [3:0] code);
    case (code)
      EXT_ADD, EXT_SUB, EXT_CMP: uses_sext = 1'b1;
      default: uses_sext = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cr16_if.sv
// Instruction handshake and retire/status bus of the CR16 execute core.
// master: instruction source (fetch unit / harness); slave: the core.
interface cr16_if #(
  parameter int DATA_W = 16
);
  logic [15:0]       instr;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] in_data;
  logic              done;
  logic              err;
  logic [4:0]        flags;

  modport master (
    output instr, instr_valid, in_data,
    input  instr_ready, done, err, flags
  );

  modport slave (
    input  instr, instr_valid, in_data,
    output instr_ready, done, err, flags
  );
endinterface

// File: rtl/cr16_alu_unit.sv
// Combinational ALU of the CR16 core: add/sub with carry and overflow,
// bitwise ops, move, logical shifts and compare bits of a against b.
module cr16_alu_unit
  import cr16_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  alu_op_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [4:0]        shamt,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              overflow,
  output logic              eq,
  output logic              lt_u,
  output logic              lt_s
);
  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  assign eq   = (a == b);
  assign lt_u = (a < b);
  assign lt_s = ($signed(a) < $signed(b));

  // Result select; shifts by at least DATA_W naturally produce zero
  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      ALU_ADD: begin
        result   = sum[DATA_W-1:0];
        carry    = sum[DATA_W];
        overflow = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        result   = diff[DATA_W-1:0];
        carry    = diff[DATA_W];
        overflow = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_MOVB: result = b;
      ALU_SHL:  result = a << shamt;
      ALU_SHR:  result = a >> shamt;
      default:  result = '0;
    endcase
  end
endmodule

// File: rtl/cr16_multicycle_core.sv
// CR16-subset multicycle execute core: register file, decode, immediate
// extension and the IDLE/DECODE/EXEC/WB control FSM around cr16_alu_unit.
// Optional feature macro CR16_FLAGS_EN: when defined, the {C,L,F,Z,N}
// status register exists and is updated at writeback; otherwise flags=0
// and compares retire as no-ops.
module cr16_multicycle_core
  import cr16_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              reset,
  cr16_if.slave             bus,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  state_t state, state_next;
  logic   ready_q, done_q, err_q;

  logic [15:0]       instr_q;
  logic [DATA_W-1:0] in_data_q;
  logic [DATA_W-1:0] regs [NUM_REGS];

  // Instruction fields
  logic [3:0] op, rd, ext, rs;
  logic [7:0] imm;
  assign op  = instr_q[15:12];
  assign rd  = instr_q[11:8];
  assign ext = instr_q[7:4];
  assign rs  = instr_q[3:0];
  assign imm = instr_q[7:0];

  logic              rd_ok, rs_ok;
  logic [DATA_W-1:0] rd_val, rs_val, imm_sext, imm_zext;
  assign rd_ok    = (int'(rd) < NUM_REGS);
  assign rs_ok    = (int'(rs) < NUM_REGS);
  assign rd_val   = rd_ok ? regs[rd] : '0;
  assign rs_val   = rs_ok ? regs[rs] : '0;
  assign imm_sext = {{(DATA_W-8){imm[7]}}, imm};
  assign imm_zext = {{(DATA_W-8){1'b0}}, imm};

  // Decode results
  logic              dec_illegal, dec_we, alu_form;
  flag_upd_t         dec_fu;
  alu_op_t           dec_alu;
  logic [DATA_W-1:0] dec_b;
  logic [4:0]        dec_shamt, lsh_amt;
  logic [3:0]        code;

  // Latched operands/control (DECODE) and results (EXEC)
  logic [DATA_W-1:0] a_q, b_q, result_q;
  logic [4:0]        shamt_q;
  alu_op_t           alu_op_q;
  flag_upd_t         fu_q;
  logic              we_q, illegal_q;
  logic [3:0]        rd_q;

  logic [DATA_W-1:0] alu_result;
  logic              alu_carry, alu_ovf, alu_eq, alu_lt_u, alu_lt_s;

  cr16_alu_unit #(.DATA_W(DATA_W)) u_alu (
    .op       (alu_op_q),
    .a        (a_q),
    .b        (b_q),
    .shamt    (shamt_q),
    .result   (alu_result),
    .carry    (alu_carry),
    .overflow (alu_ovf),
    .eq       (alu_eq),
    .lt_u     (alu_lt_u),
    .lt_s     (alu_lt_s)
  );

  // Next-state logic: one instruction walks IDLE->DECODE->EXEC->WB
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (bus.instr_valid) state_next = ST_DECODE;
        else                 state_next = ST_IDLE;
      end
      ST_DECODE: state_next = ST_EXEC;
      ST_EXEC:   state_next = ST_WB;
      ST_WB:     state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // State register and registered ready/done/err derived from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_next;
      ready_q <= (state_next == ST_IDLE);
      done_q  <= (state_next == ST_WB);
      err_q   <= (state_next == ST_WB) && illegal_q;
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;

  // Capture instruction and external data on accept; later changes are ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q   <= 16'h0000;
      in_data_q <= '0;
    end else if (state == ST_IDLE && bus.instr_valid) begin
      instr_q   <= bus.instr;
      in_data_q <= bus.in_data;
    end
  end

  // Instruction decode: legality, ALU select, B operand and shift amount
  always_comb begin
    dec_illegal = 1'b1;
    dec_we      = 1'b0;
    dec_fu      = FU_NONE;
    dec_alu     = ALU_MOVB;
    dec_b       = rs_val;
    dec_shamt   = 5'd0;
    alu_form    = 1'b0;
    code        = EXT_MOV;
    lsh_amt     = rs_val[4:0];
    case (op)
      OP_RR: begin
        if (is_alu_code(ext)) begin
          alu_form    = 1'b1;
          code        = ext;
          dec_illegal = !(rd_ok && rs_ok);
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OP_SHIFT: begin
        dec_we = 1'b1;
        if (ext == EXT_LSH) begin
          // Register shift: low five bits of rs are a signed count, negative = right
          dec_illegal = !(rd_ok && rs_ok);
          if (lsh_amt[4]) begin
            dec_alu   = ALU_SHR;
            dec_shamt = 5'd0 - lsh_amt;
          end else begin
            dec_alu   = ALU_SHL;
            dec_shamt = lsh_amt;
          end
        end else if (ext[3:1] == 3'b000) begin
          dec_illegal = !rd_ok;
          dec_shamt   = {1'b0, rs};
          if (ext[0]) dec_alu = ALU_SHR;
          else        dec_alu = ALU_SHL;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OP_LDX: begin
        dec_illegal = !rd_ok;
        dec_we      = 1'b1;
        dec_alu     = ALU_MOVB;
        dec_b       = in_data_q;
      end
      default: begin
        if (is_alu_code(op)) begin
          alu_form    = 1'b1;
          code        = op;
          dec_illegal = !rd_ok;
          dec_b       = uses_sext(op) ? imm_sext : imm_zext;
        end else begin
          dec_illegal = 1'b1;
        end
      end
    endcase
    if (alu_form) begin
      case (code)
        EXT_ADD: begin dec_alu = ALU_ADD;  dec_we = 1'b1; dec_fu = FU_ARITH; end
        EXT_SUB: begin dec_alu = ALU_SUB;  dec_we = 1'b1; dec_fu = FU_ARITH; end
        EXT_CMP: begin dec_alu = ALU_SUB;  dec_we = 1'b0; dec_fu = FU_CMP;   end
        EXT_AND: begin dec_alu = ALU_AND;  dec_we = 1'b1; end
        EXT_OR:  begin dec_alu = ALU_OR;   dec_we = 1'b1; end
        EXT_XOR: begin dec_alu = ALU_XOR;  dec_we = 1'b1; end
        EXT_MOV: begin dec_alu = ALU_MOVB; dec_we = 1'b1; end
        default: dec_illegal = 1'b1;
      endcase
    end else begin
      code = EXT_MOV;
    end
  end

  // Latch operands and control at the end of DECODE; illegal ops lose all side effects
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      shamt_q   <= 5'd0;
      alu_op_q  <= ALU_ADD;
      fu_q      <= FU_NONE;
      we_q      <= 1'b0;
      illegal_q <= 1'b0;
      rd_q      <= 4'd0;
    end else if (state == ST_DECODE) begin
      a_q       <= rd_val;
      b_q       <= dec_b;
      shamt_q   <= dec_shamt;
      alu_op_q  <= dec_alu;
      fu_q      <= dec_illegal ? FU_NONE : dec_fu;
      we_q      <= dec_we && !dec_illegal;
      illegal_q <= dec_illegal;
      rd_q      <= rd;
    end
  end

  // Latch the ALU result at the end of EXEC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
    end else if (state == ST_EXEC) begin
      result_q <= alu_result;
    end
  end

  // Register file: cleared by reset, written at the edge that ends WB
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (state == ST_WB && we_q) begin
      regs[rd_q] <= result_q;
    end
  end

  assign dbg_data = (int'(dbg_addr) < NUM_REGS) ? regs[dbg_addr] : '0;

`ifdef CR16_FLAGS_EN
  logic [4:0] flags_q, flags_nxt_q, flags_calc;

  // Next-flag computation: arithmetic sets C/F, compare sets Z/L/N, others hold
  always_comb begin
    flags_calc = flags_q;
    case (fu_q)
      FU_ARITH: begin
        flags_calc[FLAG_C] = alu_carry;
        flags_calc[FLAG_F] = alu_ovf;
      end
      FU_CMP: begin
        flags_calc[FLAG_Z] = alu_eq;
        flags_calc[FLAG_L] = alu_lt_u;
        flags_calc[FLAG_N] = alu_lt_s;
      end
      default: flags_calc = flags_q;
    endcase
  end

  // Latch next flags in EXEC and commit them at the edge that ends WB
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q     <= 5'd0;
      flags_nxt_q <= 5'd0;
    end else begin
      if (state == ST_EXEC) flags_nxt_q <= flags_calc;
      if (state == ST_WB)   flags_q     <= flags_nxt_q;
    end
  end

  assign bus.flags = flags_q;
`else
  // Without a status register the compare bits and flag-group select are dropped
  logic unused_flag_inputs;
  assign unused_flag_inputs = ^{alu_carry, alu_ovf, alu_eq, alu_lt_u, alu_lt_s, fu_q};
  assign bus.flags = 5'd0;
`endif

endmodule

// File: tb/tb_cr16_multicycle_core.sv
// Self-checking bench for cr16_multicycle_core (DATA_W=16, NUM_REGS=12).
// An arithmetic reference model tracks registers/flags; a compare process
// checks ready/done/err/flags/dbg_data every cycle, and literal peeks pin
// the model to hand-computed values.
module tb_cr16_multicycle_core;
  localparam int W  = 16;
  localparam int NR = 12;
`ifdef CR16_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [3:0]    dbg_addr;
  logic [W-1:0]  dbg_data;

  cr16_if #(.DATA_W(W)) bus ();

  cr16_multicycle_core #(.DATA_W(W), .NUM_REGS(NR)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state and expected outputs
  logic [15:0] mregs [16];
  logic [4:0]  mflags;
  logic        exp_ready, exp_done, exp_err;
  logic        checking;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (checking) begin
      chk("instr_ready", 32'(bus.instr_ready), 32'(exp_ready));
      chk("done", 32'(bus.done), 32'(exp_done));
      chk("err", 32'(bus.err), 32'(exp_err));
      chk("flags", 32'(bus.flags), FLAGS_ON ? 32'(mflags) : 32'd0);
      chk("dbg_data", 32'(dbg_data), (int'(dbg_addr) < NR) ? 32'(mregs[dbg_addr]) : 32'd0);
    end
  end

  function automatic bit is_code(input int c);
    return (c == 5) || (c == 9) || (c == 11) || (c == 1) || (c == 2) || (c == 3) || (c == 13);
  endfunction

  function automatic int to_signed(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  // Reference semantics written directly from the instruction rules
  task automatic model_step(input logic [15:0] ins, input logic [15:0] data,
                            output logic e, output logic wr, output logic [15:0] val,
                            output logic [4:0] nf);
    int op, rd, ext, rs, imm, a, b, r, s, rsv, code;
    op  = int'(ins[15:12]);
    rd  = int'(ins[11:8]);
    ext = int'(ins[7:4]);
    rs  = int'(ins[3:0]);
    imm = int'(ins[7:0]);
    e = 1'b1; wr = 1'b0; val = 16'h0; nf = mflags; code = -1; b = 0;
    a   = (rd < NR) ? int'(mregs[rd]) : 0;
    rsv = (rs < NR) ? int'(mregs[rs]) : 0;
    if (op == 0) begin
      if (is_code(ext) && rd < NR && rs < NR) begin code = ext; b = rsv; end
    end else if (is_code(op)) begin
      if (rd < NR) begin
        code = op;
        if (op == 5 || op == 9 || op == 11) b = (imm >= 128) ? imm + 65280 : imm;
        else b = imm;
      end
    end else if (op == 8) begin
      if (ext == 4 && rd < NR && rs < NR) begin
        s = rsv % 32;
        if (s >= 16) s = s - 32;
        e = 1'b0; wr = 1'b1;
        if (s >= 0) val = 16'((a << s) % 65536);
        else if (-s >= 16) val = 16'h0;
        else val = 16'(a >> (-s));
      end else if (ext < 2 && rd < NR) begin
        e = 1'b0; wr = 1'b1;
        if (ext == 1) val = 16'(a >> rs);
        else val = 16'((a << rs) % 65536);
      end
    end else if (op == 15 && rd < NR) begin
      e = 1'b0; wr = 1'b1; val = data;
    end
    if (code >= 0) begin
      e = 1'b0;
      case (code)
        5: begin
          r = a + b; wr = 1'b1; val = 16'(r % 65536);
          nf[4] = (r > 65535);
          r = to_signed(a) + to_signed(b);
          nf[2] = (r > 32767) || (r < -32768);
        end
        9: begin
          r = a - b; wr = 1'b1; val = 16'((r + 65536) % 65536);
          nf[4] = (a < b);
          r = to_signed(a) - to_signed(b);
          nf[2] = (r > 32767) || (r < -32768);
        end
        11: begin
          nf[1] = (a == b);
          nf[3] = (a < b);
          nf[0] = (to_signed(a) < to_signed(b));
        end
        1:  begin wr = 1'b1; val = 16'(a & b); end
        2:  begin wr = 1'b1; val = 16'(a | b); end
        3:  begin wr = 1'b1; val = 16'(a ^ b); end
        13: begin wr = 1'b1; val = 16'(b); end
        default: e = 1'b1;
      endcase
    end
  endtask

  // Issue one instruction and advance expectations along the 4-cycle timeline
  task automatic issue(input logic [15:0] ins, input logic [15:0] data);
    logic e, wr;
    logic [15:0] val;
    logic [4:0] nf;
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.instr_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=ready_low required=ready_high");
    end
    #1;
    bus.instr = ins; bus.in_data = data; bus.instr_valid = 1'b1;
    dbg_addr = ins[11:8];
    model_step(ins, data, e, wr, val, nf);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0; bus.instr = 16'hFFFF; bus.in_data = ~data;
    exp_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    exp_done = 1'b1; exp_err = e;
    @(posedge clk); #1;
    exp_done = 1'b0; exp_err = 1'b0; exp_ready = 1'b1;
    if (wr) mregs[ins[11:8]] = val;
    mflags = nf;
  endtask

  task automatic peek(input string name, input logic [3:0] addr, input logic [15:0] exp);
    @(negedge clk); #1;
    dbg_addr = addr;
    #1;
    chk(name, 32'(dbg_data), 32'(exp));
  endtask

  task automatic peek_flags(input string name, input logic [4:0] exp);
    @(negedge clk); #1;
    chk(name, 32'(bus.flags), FLAGS_ON ? 32'(exp) : 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; checking = 1'b0; dbg_addr = 4'd0;
    bus.instr = 16'h0000; bus.instr_valid = 1'b0; bus.in_data = 16'h0000;
    for (int i = 0; i < 16; i++) mregs[i] = 16'h0;
    mflags = 5'd0; exp_ready = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    checking = 1'b1;
    peek("reset_r0", 4'd0, 16'h0000);
    peek_flags("reset_flags", 5'b00000);

    issue(16'hF300, 16'h1234);                 // LDX r3
    peek("ldx_r3", 4'd3, 16'h1234);

    issue(16'hF100, 16'h7FFF);
    issue(16'hF200, 16'h0001);
    issue(16'h0152, 16'h0000);                 // ADD r1,r2
    peek("add_ovf_r1", 4'd1, 16'h8000);
    peek_flags("add_ovf_flags", 5'b00100);

    issue(16'hF100, 16'hFFFF);
    issue(16'h0152, 16'h0000);                 // ADD r1,r2 -> carry
    peek("add_carry_r1", 4'd1, 16'h0000);
    peek_flags("add_carry_flags", 5'b10000);

    issue(16'hF400, 16'h0005);
    issue(16'h54FF, 16'h0000);                 // ADDI r4,0xFF
    peek("addi_r4", 4'd4, 16'h0004);

    issue(16'hF500, 16'hFFFF);
    issue(16'h15FF, 16'h0000);                 // ANDI r5,0xFF
    peek("andi_r5", 4'd5, 16'h00FF);

    issue(16'hF100, 16'h0003);
    issue(16'hF200, 16'h0005);
    issue(16'h01B2, 16'h0000);                 // CMP r1,r2
    peek("cmp_r1", 4'd1, 16'h0003);
    peek_flags("cmp_flags", 5'b11001);

    issue(16'hF600, 16'h8000);
    issue(16'h8614, 16'h0000);                 // LSHI right 4
    peek("lshi_r6", 4'd6, 16'h0800);

    issue(16'hF700, 16'h0003);
    issue(16'hF800, 16'h001F);
    issue(16'h8748, 16'h0000);                 // LSH r7,r8 (-1)
    peek("lsh_r7", 4'd7, 16'h0001);

    issue(16'hF900, 16'h0010);
    issue(16'hFA00, 16'hFFFF);
    issue(16'h8A49, 16'h0000);                 // LSH by -16 -> 0
    peek("lsh_m16_r10", 4'd10, 16'h0000);

    issue(16'hFB00, 16'h0003);
    issue(16'h8B0F, 16'h0000);                 // LSHI left 15
    peek("lshi_l15_r11", 4'd11, 16'h8000);
    issue(16'h9B01, 16'h0000);                 // SUBI r11,1
    peek("subi_r11", 4'd11, 16'h7FFF);
    peek_flags("subi_flags", 5'b01101);

    issue(16'h33A5, 16'h0000);                 // XORI r3
    issue(16'h2380, 16'h0000);                 // ORI r3
    issue(16'h03D3, 16'h0000);                 // MOV r3,r3
    issue(16'h0393, 16'h0000);                 // SUB r3,r3
    peek("sub_self_r3", 4'd3, 16'h0000);

    issue(16'h7123, 16'h0000);                 // illegal opcode
    issue(16'hDD12, 16'h0000);                 // MOVI r13: rd out of range
    issue(16'h015C, 16'h0000);                 // ADD r1,r12: rs out of range
    issue(16'h8150, 16'h0000);                 // undefined shift ext
    peek("illegal_r1", 4'd1, 16'h0003);
    peek("dbg_oob", 4'd14, 16'h0000);

    // Reset while MOVI r2,0x55 is in EXEC
    @(negedge clk); #1;
    bus.instr = 16'hD255; bus.instr_valid = 1'b1; dbg_addr = 4'd2;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0; exp_ready = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    for (int i = 0; i < 16; i++) mregs[i] = 16'h0;
    mflags = 5'd0; exp_ready = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    peek("mid_reset_r2", 4'd2, 16'h0000);
    peek("mid_reset_r6", 4'd6, 16'h0000);
    peek_flags("mid_reset_flags", 5'b00000);

    issue(16'hD255, 16'h0000);                 // MOVI r2,0x55
    peek("movi_r2", 4'd2, 16'h0055);

    repeat (2) @(negedge clk);
    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
